// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, sequencer states and default width
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADDU = 4'b0010;
    localparam logic [3:0] ALU_SUBU = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_datapath.sv
// rtl/mul_datapath.sv - shift-add multiply registers, adder and shifters
module mul_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] acc_nxt_o
);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;

    // Accumulator value after the current step; the FSM captures it on the last one.
    assign acc_nxt_o = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= src1_i;
            mplier_q <= src2_i;
            acc_q    <= '0;
        end else if (step_i) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_nxt_o;
        end
    end

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative multiply sequencer that stalls the front end for WIDTH cycles
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int         WIDTH    = WIDTH_DEF,
    parameter int         CNT_W    = 6,
    parameter logic [3:0] MUL_CODE = ALU_MUL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             load, step, req;
    logic [WIDTH-1:0] acc_nxt;

    assign req      = valid_i && (ALUCtrl_i == MUL_CODE);
    assign result_o = result_q;

    mul_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (load),
        .step_i    (step),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .acc_nxt_o (acc_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        ready_o  = 1'b0;
        stall_o  = 1'b0;
        valid_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                stall_o = req;
                if (req && !flush_i) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_o = 1'b1;
                // A flush on the final step still discards the product.
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = acc_nxt;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                valid_o = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - scoreboard bench for the multiply sequencer
module tb_alu_mul_seq;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] r;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, valid, flush;
    logic [3:0]  ctrl;
    logic [31:0] src1, src2;
    logic        ready_o, stall_o, valid_o;
    logic [31:0] result_o;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] last_result = '0;
    exp_t        sb[$];

    alu_mul_seq dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .ALUCtrl_i (ctrl),
        .src1_i    (src1),
        .src2_i    (src2),
        .flush_i   (flush),
        .ready_o   (ready_o),
        .stall_o   (stall_o),
        .valid_o   (valid_o),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("result", result_o, e.r);
                chk("latency", cyc - e.t, 32);
                chk("stall_in_done", stall_o, 0);
                chk("ready_in_done", ready_o, 0);
                last_result = e.r;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // abort_at: BUSY count at which flush (or reset) is applied, -1 for none.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int abort_at,
                          input bit use_rst, input int poke_at, input bit hold);
        int          guard;
        int          k;
        logic [31:0] prod;
        guard = 0;
        @(negedge clk);
        while (!ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) chk("ready_wait", 0, 1);
        valid = 1'b1;
        ctrl  = ALU_MUL;
        src1  = a;
        src2  = b;
        #1 chk("stall_req", stall_o, 1);
        @(posedge clk);
        #1;
        prod = a * b;
        if (abort_at < 0) begin
            sb.push_back('{prod, cyc});
            k = 0;
            forever begin
                @(negedge clk);
                if (k == poke_at) src1 = 32'd100;
                if (!stall_o || k > 40) break;
                k++;
            end
            if (stall_o) chk("done_wait", 0, 1);
            if (!hold) valid = 1'b0;
        end else begin
            repeat (abort_at + 1) @(negedge clk);
            if (use_rst) rst = 1'b1;
            else flush = 1'b1;
            @(posedge clk);
            #1;
            rst   = 1'b0;
            flush = 1'b0;
            valid = 1'b0;
            if (use_rst) last_result = '0;
            chk(use_rst ? "rst_ready" : "flush_ready", ready_o, 1);
            chk(use_rst ? "rst_result" : "flush_result", result_o, last_result);
            chk(use_rst ? "rst_valid" : "flush_valid", valid_o, 0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        flush = 1'b0;
        ctrl  = ALU_ADDU;
        src1  = '0;
        src2  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", ready_o, 1);
        chk("reset_stall", stall_o, 0);
        chk("reset_valid", valid_o, 0);
        chk("reset_result", result_o, 0);

        do_mul(32'd3, 32'd5, -1, 0, -1, 0);
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, -1, 0);
        do_mul(32'h00010000, 32'h00010000, -1, 0, -1, 0);
        do_mul(32'hFFFFFFFD, 32'd5, -1, 0, -1, 0);

        do_mul(32'd9, 32'd9, 10, 0, -1, 0);
        do_mul(32'd7, 32'd6, -1, 0, -1, 0);
        do_mul(32'd11, 32'd13, 20, 1, -1, 0);

        @(negedge clk);
        valid = 1'b1;
        ctrl  = ALU_ADDU;
        src1  = 32'd1;
        src2  = 32'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("addu_stall", stall_o, 0);
            chk("addu_ready", ready_o, 1);
            chk("addu_result_hold", result_o, last_result);
        end
        valid = 1'b0;

        do_mul(32'd4, 32'd4, -1, 0, 5, 1);
        @(negedge clk);
        chk("hold_idle_ready", ready_o, 1);
        chk("hold_idle_stall", stall_o, 1);
        @(posedge clk);
        #1 sb.push_back('{32'd400, cyc});
        for (int g = 0; g < 40 && (g == 0 || stall_o); g++) @(negedge clk);
        valid = 1'b0;

        for (int n = 0; n < 16; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (n % 4 == 0) ? $urandom_range(0, 255) : $urandom;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                valid = $urandom_range(0, 1);
                ctrl  = 4'($urandom_range(0, 7));
            end
            if (n % 5 == 4) do_mul(a, b, $urandom_range(0, 31), 0, -1, 0);
            else do_mul(a, b, -1, 0, -1, 0);
        end

        repeat (40) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative shift-add sequencer for the ALU multiply operation (ALU control code 4'b1000, `mul`).
- Sits beside the single-cycle ALU. When the decoded control code is MUL, it stalls the CPU front end for WIDTH cycles, then delivers the low WIDTH bits of the product.
- All other ALU control codes pass through untouched; this block ignores them.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.
- MUL_CODE, 4'b1000, ALU control value that selects this unit.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  request; the instruction is presented to the ALU stage.
- ALUCtrl_i  input  4  ALU control code from the ALU control decoder.
- src1_i  input  WIDTH  multiplicand.
- src2_i  input  WIDTH  multiplier.
- flush_i  input  1  aborts an in-flight multiply.
- ready_o  output  1  unit idle and able to accept a request.
- stall_o  output  1  freeze PC and the ALU-stage instruction.
- valid_o  output  1  one-cycle pulse; result_o is valid.
- result_o  output  WIDTH  low WIDTH bits of src1*src2.

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, counter=0, accumulator=0, result_o=0, valid_o=0. Reset wins over every other input, including mid-operation; an in-flight product is discarded.
- is_mul = (ALUCtrl_i == MUL_CODE).
- State IDLE:
  - ready_o=1.
  - stall_o = valid_i & is_mul (combinational, so the requesting instruction is frozen in the same cycle).
  - On an edge with valid_i & is_mul & !flush_i: latch mcand=src1_i, mplier=src2_i; set acc=0, cnt=0; go to BUSY.
  - valid_i with a non-MUL code: no state change, stall_o=0.
- State BUSY:
  - ready_o=0, stall_o=1.
  - Each edge:
    - if mplier[0], then acc <= acc + mcand (mod 2**WIDTH);
    - mcand <= mcand << 1;
    - mplier <= mplier >> 1 (logical shift);
    - cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1: result_o <= the final acc value, go to DONE.
  - flush_i=1 at any BUSY edge: go to IDLE. result_o is not updated and valid_o is not pulsed.
- State DONE:
  - valid_o=1, stall_o=0, ready_o=0.
  - The next edge unconditionally returns to IDLE; flush_i has no effect in DONE.
  - valid_i is ignored, because it is still the same stalled instruction.
- Latency: valid_o is high in the cycle following the WIDTH-th edge after the acceptance edge. The unit occupies WIDTH+2 cycles from request to retire.
- Requester contract: valid_i, ALUCtrl_i and the operands stay stable while stall_o=1. Operands are latched at acceptance, so later changes do not affect the result.
- Arithmetic: unsigned shift-add truncated to WIDTH bits. This equals the two's-complement low word, so signed operands need no special handling.
- result_o holds its last value between completions; it changes only on entry to DONE or on reset.
- Back-to-back multiplies: a new request is accepted only in IDLE, so a minimum of one IDLE cycle separates consecutive operations.

Decomposition:
- Shared package (alu_pkg):
  - ALU control code constants (MUL_CODE and the other 4-bit codes);
  - state enum {IDLE, BUSY, DONE};
  - default WIDTH.
- One natural sub-module: mul_datapath, holding the mcand/mplier/acc registers, adder and shifters, controlled by load/step enables from the FSM in alu_mul_seq.

Test Plan:
1. IDLE, valid_i=1, ALUCtrl_i=4'b1000, src1=3, src2=5 → stall_o=1 in the request cycle; valid_o pulses exactly 32 edges after acceptance with result_o=15; stall_o drops in that same cycle.
2. src1=32'hFFFFFFFF, src2=32'hFFFFFFFF → result_o=32'h00000001. src1=32'h00010000, src2=32'h00010000 → result_o=0 (truncation). src1=32'hFFFFFFFD (-3), src2=5 → 32'hFFFFFFF1.
3. Multiply 9*9, then flush_i=1 at BUSY cnt=10 → IDLE next cycle, no valid_o, result_o unchanged. A following multiply 7*6 → result_o=42 after 32 edges.
4. rst_i=1 at BUSY cnt=20 → next cycle state=IDLE, result_o=0, valid_o=0, ready_o=1.
5. valid_i=1, ALUCtrl_i=4'b0010 (addu) in IDLE → stall_o=0, ready_o stays 1, no valid_o ever.
6. Operands change while BUSY: start 4*4, set src1=100 mid-operation → result_o=16. A second request held across DONE → accepted only after the IDLE cycle.
